// File: rtl/clock_period_meter.sv
// Clock period meter: synchronises an asynchronous square wave and reports its
// half-period and full period in clk cycles, with lock and loss-of-signal flags.
module clock_period_meter #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned TIMEOUT     = 1000000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             sig_in_i,
   output logic [WIDTH-1:0] half_period_o,
   output logic [WIDTH:0]   period_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             timeout_o
);

   localparam logic [WIDTH-1:0] CntMax     = '1;
   localparam logic [WIDTH-1:0] TimeoutVal = WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      MEAS  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [WIDTH-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       half_q, half_d;
   logic [WIDTH:0]         period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   locked_q, locked_d;
   logic                   timeout_q, timeout_d;
   logic                   edge_c;
   logic                   tmo_hit_c;

   // Synchroniser chain plus previous-value flop for both-edge detection.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_c    = sync_q[SYNC_STAGES-1] ^ prev_q;
   // An edge in the same cycle as the timeout threshold takes priority.
   assign tmo_hit_c = (cnt_q == TimeoutVal) && !edge_c;

   always_comb begin
      cnt_d = cnt_q;
      if (edge_c) begin
         cnt_d = WIDTH'(1);
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (edge_c) state_d = ARMED;
         ARMED:   if (edge_c) state_d = MEAS;
                  else if (tmo_hit_c) state_d = IDLE;
         MEAS:    if (tmo_hit_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      half_d    = half_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (edge_c) timeout_d = 1'b0;
         end
         ARMED, MEAS: begin
            if (edge_c) begin
               half_d  = cnt_q;
               valid_d = 1'b1;
               if (state_q == ARMED) begin
                  period_d = {1'b0, cnt_q};
                  locked_d = 1'b0;
               end else begin
                  period_d = {1'b0, half_q} + {1'b0, cnt_q};
                  locked_d = (cnt_q == half_q);
               end
            end else if (tmo_hit_c) begin
               half_d    = '0;
               period_d  = '0;
               locked_d  = 1'b0;
               timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_q     <= '0;
         half_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign half_period_o = half_q;
   assign period_o      = period_q;
   assign valid_o       = valid_q;
   assign locked_o      = locked_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised scoreboard bench for clock_period_meter: expected measurements are
// derived from the toggle times of sig_in and checked when valid pulses.
module tb_clock_period_meter;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned TIMEOUT = 200;
   localparam int unsigned SYNC    = 2;
   localparam int          LAT     = SYNC + 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             sig;
   logic [WIDTH-1:0] half_period;
   logic [WIDTH:0]   period;
   logic             valid;
   logic             locked;
   logic             timeout;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int half;
      int per;
      bit lk;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state: time of the reference toggle and last half-period.
   bit have_ref;
   bit have_half;
   int last_t;
   int prev_half;

   clock_period_meter #(
      .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
   ) dut (
      .clk_i(clk), .reset_i(reset_n), .sig_in_i(sig),
      .half_period_o(half_period), .period_o(period), .valid_o(valid),
      .locked_o(locked), .timeout_o(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic model_reset();
      have_ref  = 1'b0;
      have_half = 1'b0;
   endtask

   task automatic model_toggle(input int t);
      exp_t e;
      int   gap;
      if (!have_ref) begin
         have_ref = 1'b1;
         last_t   = t;
      end else begin
         gap = t - last_t;
         last_t = t;
         if (gap > int'(TIMEOUT)) begin
            have_half = 1'b0;
         end else begin
            e.cyc  = t + LAT;
            e.half = gap;
            e.per  = have_half ? prev_half + gap : gap;
            e.lk   = have_half && (gap == prev_half);
            exp_q.push_back(e);
            prev_half = gap;
            have_half = 1'b1;
         end
      end
   endtask

   task automatic tog(input int n);
      repeat (n) @(negedge clk);
      sig = ~sig;
      model_toggle(cyc);
   endtask

   task automatic check_zero(input string tag);
      #1;
      check({tag, "_half"}, 64'(half_period), 64'd0);
      check({tag, "_period"}, 64'(period), 64'd0);
      check({tag, "_valid"}, 64'(valid), 64'd0);
      check({tag, "_locked"}, 64'(locked), 64'd0);
      check({tag, "_timeout"}, 64'(timeout), 64'd0);
   endtask

   // Monitor: every valid pulse must match the oldest expected measurement.
   always @(negedge clk) begin
      if (valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid at cyc %0d: got half %0d expected no valid", cyc, half_period);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_cycle", 64'(cyc), 64'(e.cyc));
            check("half_period", 64'(half_period), 64'(e.half));
            check("period", 64'(period), 64'(e.per));
            check("locked", 64'(locked), 64'(e.lk));
            check("timeout_on_valid", 64'(timeout), 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      sig     = 1'b0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // Divider default: toggle every 50 cycles.
      tog(1);
      repeat (5) tog(50);

      // Interval switch 50 -> 10.
      repeat (4) tog(10);

      // Random runs of repeated intervals so lock both drops and re-asserts.
      repeat (30) begin
         v = $urandom_range(60, 2);
         repeat ($urandom_range(4, 1)) tog(v);
      end

      // Gap exactly TIMEOUT: the edge wins and is a normal measurement.
      tog(int'(TIMEOUT));
      repeat (2) tog(50);

      // Loss of signal.
      repeat (int'(TIMEOUT) + LAT - 1) @(negedge clk);
      #1 check("timeout_before", 64'(timeout), 64'd0);
      @(negedge clk);
      #1;
      check("timeout_set", 64'(timeout), 64'd1);
      check("timeout_locked", 64'(locked), 64'd0);
      check("timeout_half", 64'(half_period), 64'd0);
      check("timeout_period", 64'(period), 64'd0);
      tog(5);
      repeat (LAT) @(negedge clk);
      #1 check("timeout_cleared", 64'(timeout), 64'd0);
      repeat (2) tog(30);

      // Reset mid half-period with sig low discards history.
      if (sig) tog(20);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      check_zero("midreset");
      tog(15);
      repeat (2) tog(25);

      // Minimum half-period.
      repeat (12) tog(2);
      repeat (LAT + 1) @(negedge clk);
      #1;
      check("min_half", 64'(half_period), 64'd2);
      check("min_period", 64'(period), 64'd4);
      check("min_locked", 64'(locked), 64'd1);

      repeat (10) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
